// File: rtl/data_mem_arbiter.sv
// data_mem_arbiter: shares one single-port SRAM between fetch and memory stage.
// Fixed wait-state access, one-cycle ready pulse, alternating grant on contention.
module data_mem_arbiter #(
  parameter int          WAIT_CYCLES = 4,
  parameter int          ADDR_W      = 16,
  parameter logic [31:0] MEM_BASE    = 32'd1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [31:0]       if_addr,
  output logic [31:0]       if_rdata,
  output logic              if_ready,
  input  logic              mem_r_en,
  input  logic              mem_w_en,
  input  logic [31:0]       mem_addr,
  input  logic [31:0]       mem_wdata,
  output logic [31:0]       mem_rdata,
  output logic              mem_ready,
  output logic              freeze_if,
  output logic              freeze_mem,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [31:0]       sram_wdata,
  input  logic [31:0]       sram_rdata,
  output logic              sram_we_n,
  output logic              sram_oe_n
);

  typedef enum logic [1:0] {
    IDLE,
    ACC,
    RESP
  } state_t;

  state_t state, state_nx;

  logic [3:0] cnt;
  logic       last_mem;
  logic       gnt_mem;
  logic       op_wr;
  logic       mem_any;
  logic       pick_mem;
  logic       any_req;

  logic [ADDR_W-1:0] if_word;
  logic [ADDR_W-1:0] mem_word;

  assign mem_any = mem_r_en | mem_w_en;
  assign any_req = if_req | mem_any;

  // On contention the memory stage wins unless it won last time.
  assign pick_mem = mem_any & (~if_req | ~last_mem);

  assign if_word  = ADDR_W'((if_addr - MEM_BASE) >> 2);
  assign mem_word = ADDR_W'((mem_addr - MEM_BASE) >> 2);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (any_req) state_nx = ACC;
      ACC:  if (cnt == 4'd0) state_nx = RESP;
      RESP: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt        <= 4'd0;
      last_mem   <= 1'b0;
      gnt_mem    <= 1'b0;
      op_wr      <= 1'b0;
      sram_addr  <= '0;
      sram_wdata <= 32'd0;
      if_rdata   <= 32'd0;
      mem_rdata  <= 32'd0;
    end else begin
      unique case (state)
        IDLE: begin
          if (any_req) begin
            gnt_mem    <= pick_mem;
            last_mem   <= pick_mem;
            op_wr      <= pick_mem & mem_w_en;
            sram_addr  <= pick_mem ? mem_word : if_word;
            sram_wdata <= mem_wdata;
            cnt        <= 4'(WAIT_CYCLES - 1);
          end
        end
        ACC: begin
          if (cnt == 4'd0) begin
            if (!op_wr && gnt_mem) mem_rdata <= sram_rdata;
            if (!op_wr && !gnt_mem) if_rdata <= sram_rdata;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    sram_oe_n = 1'b1;
    sram_we_n = 1'b1;
    if_ready  = 1'b0;
    mem_ready = 1'b0;
    unique case (1'b1)
      (state == ACC): begin
        sram_oe_n = op_wr;
        sram_we_n = ~op_wr;
      end
      (state == RESP): begin
        if_ready  = ~gnt_mem;
        mem_ready = gnt_mem;
      end
      default: ;
    endcase
  end

  assign freeze_if  = if_req & ~if_ready;
  assign freeze_mem = mem_any & ~mem_ready;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// tb_data_mem_arbiter: randomized scoreboard bench for data_mem_arbiter.
// Transaction-level reference model predicts grant order, timing and data.
module tb_data_mem_arbiter;

  localparam int W = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = 32'd0;
  logic [31:0] if_rdata;
  logic        if_ready;
  logic        mem_r_en = 1'b0;
  logic        mem_w_en = 1'b0;
  logic [31:0] mem_addr = 32'd0;
  logic [31:0] mem_wdata = 32'd0;
  logic [31:0] mem_rdata;
  logic        mem_ready;
  logic        freeze_if;
  logic        freeze_mem;
  logic [15:0] sram_addr;
  logic [31:0] sram_wdata;
  logic [31:0] sram_rdata;
  logic        sram_we_n;
  logic        sram_oe_n;

  data_mem_arbiter #(
    .WAIT_CYCLES(W),
    .ADDR_W(16),
    .MEM_BASE(32'd1024)
  ) dut (
    .clk(clk),
    .rst(rst),
    .if_req(if_req),
    .if_addr(if_addr),
    .if_rdata(if_rdata),
    .if_ready(if_ready),
    .mem_r_en(mem_r_en),
    .mem_w_en(mem_w_en),
    .mem_addr(mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .mem_ready(mem_ready),
    .freeze_if(freeze_if),
    .freeze_mem(freeze_mem),
    .sram_addr(sram_addr),
    .sram_wdata(sram_wdata),
    .sram_rdata(sram_rdata),
    .sram_we_n(sram_we_n),
    .sram_oe_n(sram_oe_n)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit          mem;
    bit          wr;
    logic [31:0] data;
    logic [15:0] saddr;
    int          cyc;
  } exp_t;

  exp_t exp_q[$];
  exp_t me;
  int checks = 0;
  int errors = 0;

  logic [31:0] ref_mem [int unsigned];
  logic [31:0] last_mrd = 32'd0;
  bit          last_was_mem = 1'b0;

  function automatic logic [31:0] init_word(int unsigned i);
    if (i == 0) return 32'hE3A00005;
    return (i * 32'h9E3779B9) ^ 32'h5A5A5A5A;
  endfunction

  function automatic int unsigned widx(logic [31:0] a);
    return ((a - 32'd1024) / 4) % 65536;
  endfunction

  function automatic logic [31:0] ref_rd(int unsigned i);
    return ref_mem.exists(i) ? ref_mem[i] : init_word(i);
  endfunction

  logic [31:0] sram_mem [0:65535];
  initial for (int i = 0; i < 65536; i++) sram_mem[i] = init_word(i);
  always @(posedge clk) if (!sram_we_n) sram_mem[sram_addr] <= sram_wdata;
  assign sram_rdata = sram_oe_n ? 32'h0 : sram_mem[sram_addr];

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %h expected %h",
               nm, cyc, act, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (rst) begin
      if (if_ready || mem_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_ready at cycle %0d: if_ready=%b mem_ready=%b expected none",
                   cyc, if_ready, mem_ready);
        end else begin
          me = exp_q.pop_front();
          check("ready_who", {30'd0, if_ready, mem_ready},
                me.mem ? 32'd1 : 32'd2);
          check("ready_cycle", cyc, me.cyc);
          check("sram_addr", {16'd0, sram_addr}, {16'd0, me.saddr});
          if (me.mem) check("mem_rdata", mem_rdata, me.data);
          else check("if_rdata", if_rdata, me.data);
        end
      end else if (exp_q.size() != 0 && cyc > exp_q[0].cyc) begin
        checks++;
        errors++;
        $display("FAIL ready_timeout at cycle %0d: no ready, expected at cycle %0d",
                 cyc, exp_q[0].cyc);
        void'(exp_q.pop_front());
      end
    end
  end

  task automatic run_txn(input bit ir, input bit mr, input bit mw,
                         input logic [31:0] ia, input logic [31:0] ma,
                         input logic [31:0] wd);
    int n = cyc;
    bit many = mr | mw;
    bit g_mem[2];
    bit wr[2];
    int s[2];
    int r[2];
    int ng = 0;
    int unsigned idx;
    bit hold_if, hold_mem, oe, we, fi, fm;
    exp_t e;
    if (ir && many) begin
      g_mem[0] = !last_was_mem;
      g_mem[1] = last_was_mem;
      ng = 2;
    end else if (ir) begin
      g_mem[0] = 1'b0;
      ng = 1;
    end else if (many) begin
      g_mem[0] = 1'b1;
      ng = 1;
    end
    if (ng == 0) return;
    for (int k = 0; k < ng; k++) begin
      s[k] = n + 1 + k * (W + 2);
      r[k] = s[k] + W;
      if (g_mem[k]) begin
        wr[k] = mw;
        idx = widx(ma);
        if (mw) ref_mem[idx] = wd;
        else last_mrd = ref_rd(idx);
        e.data = last_mrd;
      end else begin
        wr[k] = 1'b0;
        idx = widx(ia);
        e.data = ref_rd(idx);
      end
      e.mem = g_mem[k];
      e.wr = wr[k];
      e.saddr = idx[15:0];
      e.cyc = r[k];
      exp_q.push_back(e);
      last_was_mem = g_mem[k];
    end
    if_req = ir;
    if_addr = ia;
    mem_r_en = mr;
    mem_w_en = mw;
    mem_addr = ma;
    mem_wdata = wd;
    hold_if = ir;
    hold_mem = many;
    for (int c = n; c <= r[ng-1] + 1; c++) begin
      if (c > n) tick();
      for (int k = 0; k < ng; k++) begin
        if (c == r[k] + 1) begin
          if (g_mem[k]) begin
            mem_r_en = 1'b0;
            mem_w_en = 1'b0;
            hold_mem = 1'b0;
          end else begin
            if_req = 1'b0;
            hold_if = 1'b0;
          end
        end
      end
      #1;
      oe = 1'b1;
      we = 1'b1;
      fi = hold_if;
      fm = hold_mem;
      for (int k = 0; k < ng; k++) begin
        if (c >= s[k] && c < r[k]) begin
          oe = wr[k];
          we = !wr[k];
        end
        if (c == r[k]) begin
          if (g_mem[k]) fm = 1'b0;
          else fi = 1'b0;
        end
      end
      check("sram_oe_n", {31'd0, sram_oe_n}, {31'd0, oe});
      check("sram_we_n", {31'd0, sram_we_n}, {31'd0, we});
      check("freeze_if", {31'd0, freeze_if}, {31'd0, fi});
      check("freeze_mem", {31'd0, freeze_mem}, {31'd0, fm});
    end
  endtask

  task automatic check_reset_outputs();
    check("rst_if_rdata", if_rdata, 32'd0);
    check("rst_mem_rdata", mem_rdata, 32'd0);
    check("rst_if_ready", {31'd0, if_ready}, 32'd0);
    check("rst_mem_ready", {31'd0, mem_ready}, 32'd0);
    check("rst_sram_addr", {16'd0, sram_addr}, 32'd0);
    check("rst_sram_wdata", sram_wdata, 32'd0);
    check("rst_sram_we_n", {31'd0, sram_we_n}, 32'd1);
    check("rst_sram_oe_n", {31'd0, sram_oe_n}, 32'd1);
  endtask

  initial begin
    int n;
    int t;
    exp_t e;
    logic [31:0] a0, a1, d0;

    repeat (2) tick();
    #1;
    check_reset_outputs();
    check("rst_freeze_if", {31'd0, freeze_if}, 32'd0);
    rst = 1'b1;
    tick();

    run_txn(1, 0, 0, 32'd1024, 32'd0, 32'd0);
    run_txn(0, 0, 1, 32'd0, 32'd1032, 32'hDEADBEEF);
    run_txn(0, 1, 0, 32'd0, 32'd1032, 32'd0);
    run_txn(1, 0, 0, 32'd1028, 32'd0, 32'd0);
    run_txn(1, 1, 0, 32'd1036, 32'd1040, 32'd0);
    run_txn(1, 1, 0, 32'd1044, 32'd1048, 32'd0);

    n = cyc;
    if_req = 1'b1;
    if_addr = 32'd1032;
    e.mem = 1'b0;
    e.wr = 1'b0;
    e.data = ref_rd(2);
    e.saddr = 16'd2;
    e.cyc = n + W + 1;
    exp_q.push_back(e);
    last_was_mem = 1'b0;
    repeat (2) tick();
    if_req = 1'b0;
    repeat (W + 3) tick();
    #1;
    check("withdraw_oe_n", {31'd0, sram_oe_n}, 32'd1);
    check("withdraw_freeze_if", {31'd0, freeze_if}, 32'd0);

    run_txn(0, 1, 0, 32'd0, 32'd1024 + 32'd262144, 32'd0);
    run_txn(0, 0, 1, 32'd0, 32'd1028 + 32'd262144, 32'h12345678);
    run_txn(1, 0, 0, 32'd1028, 32'd0, 32'd0);

    mem_w_en = 1'b1;
    mem_addr = 32'd1064;
    mem_wdata = 32'hCAFEF00D;
    ref_mem[10] = 32'hCAFEF00D;
    repeat (3) tick();
    check("midwrite_we_n", {31'd0, sram_we_n}, 32'd0);
    rst = 1'b0;
    #1;
    check_reset_outputs();
    mem_w_en = 1'b0;
    last_mrd = 32'd0;
    last_was_mem = 1'b0;
    tick();
    rst = 1'b1;
    repeat (12) tick();
    check("post_reset_mem_ready", {31'd0, mem_ready}, 32'd0);

    for (int i = 0; i < 60; i++) begin
      t = $urandom_range(0, 5);
      a0 = 32'd1024 + 4 * $urandom_range(0, 15);
      a1 = 32'd1024 + 4 * $urandom_range(0, 15);
      d0 = $urandom;
      repeat ($urandom_range(0, 2)) tick();
      case (t)
        0: run_txn(1, 0, 0, a0, a1, d0);
        1: run_txn(0, 1, 0, a0, a1, d0);
        2: run_txn(0, 0, 1, a0, a1, d0);
        3: run_txn(1, 1, 0, a0, a1, d0);
        4: run_txn(1, 0, 1, a0, a1, d0);
        default: run_txn(1, 1, 1, a0, a1, d0);
      endcase
    end

    repeat (W + 4) tick();
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL pending_ready: %0d responses outstanding, expected 0",
               exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
